// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, issues credit-limited in-order word fetches and
// buffers returned {instruction, pc} pairs for decode, discarding stale fetches on redirect.
module instruction_fetch #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] CREDIT_LIMIT = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] stale;
    logic [CW-1:0] fifo_count;
    logic [PW-1:0] tag_wr;
    logic [PW-1:0] tag_rd;
    logic [PW-1:0] fifo_wr;
    logic [PW-1:0] fifo_rd;
    logic [31:0]   tag_mem   [FIFO_DEPTH];
    logic [31:0]   instr_mem [FIFO_DEPTH];
    logic [31:0]   pc_mem    [FIFO_DEPTH];
    logic          req_fire;
    logic          fifo_push;
    logic          fifo_pop;

    // Credit uses registered counts only, so a pop frees a slot one cycle later.
    always_comb begin
        imem_req_valid   = !rst && (({1'b0, outstanding} + {1'b0, fifo_count}) < CREDIT_LIMIT);
        req_fire         = imem_req_valid && imem_req_ready;
        fifo_push        = imem_resp_valid && (stale == '0) && !redirect_valid;
        fifo_pop         = if_valid && if_ready && !redirect_valid;
        outstanding_next = outstanding + CW'(req_fire) - CW'(imem_resp_valid);
    end

    assign imem_req_addr  = pc;
    assign if_valid       = (fifo_count != '0);
    assign if_instruction = if_valid ? instr_mem[fifo_rd] : '0;
    assign if_pc          = if_valid ? pc_mem[fifo_rd] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            stale       <= '0;
            fifo_count  <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                // Everything still in flight after this cycle, including a request accepted now, is stale.
                pc         <= redirect_pc & 32'hFFFF_FFFC;
                stale      <= outstanding_next;
                fifo_count <= '0;
                tag_wr     <= '0;
                tag_rd     <= '0;
                fifo_wr    <= '0;
                fifo_rd    <= '0;
            end else begin
                if (req_fire) begin
                    pc     <= pc + 32'd4;
                    tag_wr <= tag_wr + PW'(1);
                end
                if (imem_resp_valid && (stale != '0)) begin
                    stale <= stale - CW'(1);
                end
                if (fifo_push) begin
                    fifo_wr <= fifo_wr + PW'(1);
                    tag_rd  <= tag_rd + PW'(1);
                end
                if (fifo_pop) begin
                    fifo_rd <= fifo_rd + PW'(1);
                end
                fifo_count <= fifo_count + CW'(fifo_push) - CW'(fifo_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_mem[tag_wr] <= pc;
        end
        if (fifo_push) begin
            instr_mem[fifo_wr] <= imem_resp_data;
            pc_mem[fifo_wr]    <= tag_mem[tag_rd];
        end
    end

    no_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
        !(fifo_push && !fifo_pop && (fifo_count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: scripted scenarios plus random traffic, checked
// against a transaction-level model of memory, fetch PC and the decode stream.
module tb_instruction_fetch;
    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data  = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;

    always #5 clk = ~clk;

    instruction_fetch #(.FIFO_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instruction(if_instruction), .if_pc(if_pc)
    );

    typedef struct { logic [31:0] addr; logic [31:0] pc; int due; bit stale; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    req_t        mq[$];      // accepted requests awaiting a memory response
    ent_t        exp_q[$];   // instructions decode should see, in order
    req_t        m_req;
    ent_t        m_ent;
    logic [31:0] model_pc = RST_PC;
    int          cyc = 0;
    int          lat = 1;
    int          total_hs = 0;
    int          errors = 0;
    int          checks = 0;

    // Transaction model, advanced with the values present just before each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            exp_q.delete();
            model_pc = RST_PC;
        end else begin
            if (if_valid && if_ready && !redirect_valid && exp_q.size() != 0)
                exp_q.delete(0);
            if (imem_resp_valid && mq.size() != 0) begin
                m_req = mq.pop_front();
                if (!m_req.stale && !redirect_valid) begin
                    m_ent.pc    = m_req.pc;
                    m_ent.instr = m_req.addr;
                    exp_q.push_back(m_ent);
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                m_req.addr  = imem_req_addr;
                m_req.pc    = model_pc;
                m_req.due   = cyc + lat;
                m_req.stale = redirect_valid;
                mq.push_back(m_req);
                total_hs++;
                model_pc = model_pc + 32'd4;
            end
            if (redirect_valid) begin
                foreach (mq[i]) mq[i].stale = 1'b1;
                exp_q.delete();
                model_pc = redirect_pc & 32'hFFFF_FFFC;
            end
        end
        cyc++;
    end

    // Memory returns the request address as the instruction word after lat cycles.
    always @(negedge clk) begin
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mq[0].addr;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
    end

    function automatic logic exp_credit();
        return !rst && ((mq.size() + exp_q.size()) < int'(DEPTH));
    endfunction
    function automatic logic [31:0] exp_pc();
        return (exp_q.size() != 0) ? exp_q[0].pc : 32'h0;
    endfunction
    function automatic logic [31:0] exp_instr();
        return (exp_q.size() != 0) ? exp_q[0].instr : 32'h0;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_req_ready = 1'b1; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        tick(); tick(); tick();
        checks++;
        if ({imem_req_valid, imem_req_addr, if_valid, if_instruction, if_pc} !== {1'b0, RST_PC, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_state: got req=%b addr=%h v=%b ins=%h pc=%h, expected 0 %h 0 0 0",
                     imem_req_valid, imem_req_addr, if_valid, if_instruction, if_pc, RST_PC);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, RST_PC}) begin
            errors++;
            $display("FAIL first_fetch: got req=%b addr=%h, expected 1 %h", imem_req_valid, imem_req_addr, RST_PC);
        end
    endtask

    task automatic test_stream();
        int n = 0;
        lat = 1; imem_req_ready = 1'b1; if_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({if_valid, if_pc, if_instruction, imem_req_valid} !== {exp_q.size() != 0, exp_pc(), exp_instr(), exp_credit()}) begin
                errors++;
                $display("FAIL stream_model: got v=%b pc=%h ins=%h req=%b, expected v=%b pc=%h ins=%h req=%b",
                         if_valid, if_pc, if_instruction, imem_req_valid, exp_q.size() != 0, exp_pc(), exp_instr(), exp_credit());
            end
            if (if_valid) begin
                checks++;
                if (if_pc !== RST_PC + 32'(4 * n) || if_instruction !== RST_PC + 32'(4 * n)) begin
                    errors++;
                    $display("FAIL stream_seq: got pc=%h ins=%h, expected %h", if_pc, if_instruction, RST_PC + 32'(4 * n));
                end
                n++;
            end
        end
        checks++;
        if (n != 19) begin
            errors++;
            $display("FAIL stream_rate: got %0d instructions, expected 19", n);
        end
    endtask

    task automatic test_backpressure();
        int base;
        int n = 0;
        lat = 1; imem_req_ready = 1'b1; if_ready = 1'b0;
        do_reset();
        base = total_hs;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({if_valid, if_pc, if_instruction, imem_req_valid} !== {exp_q.size() != 0, exp_pc(), exp_instr(), exp_credit()}) begin
                errors++;
                $display("FAIL bp_model: got v=%b pc=%h ins=%h req=%b, expected v=%b pc=%h ins=%h req=%b",
                         if_valid, if_pc, if_instruction, imem_req_valid, exp_q.size() != 0, exp_pc(), exp_instr(), exp_credit());
            end
        end
        checks++;
        if (total_hs - base != 4 || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_credit: got accepted=%0d req=%b, expected 4 0", total_hs - base, imem_req_valid);
        end
        if_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (if_valid) begin
                checks++;
                if (if_pc !== RST_PC + 32'(4 * n)) begin
                    errors++;
                    $display("FAIL bp_order: got pc=%h, expected %h", if_pc, RST_PC + 32'(4 * n));
                end
                n++;
            end
            tick();
            checks++;
            if ({if_valid, if_pc, if_instruction, imem_req_valid} !== {exp_q.size() != 0, exp_pc(), exp_instr(), exp_credit()}) begin
                errors++;
                $display("FAIL bp_drain_model: got v=%b pc=%h ins=%h req=%b, expected v=%b pc=%h ins=%h req=%b",
                         if_valid, if_pc, if_instruction, imem_req_valid, exp_q.size() != 0, exp_pc(), exp_instr(), exp_credit());
            end
        end
        checks++;
        if (n != 12) begin
            errors++;
            $display("FAIL bp_count: got %0d delivered, expected 12", n);
        end
    endtask

    task automatic test_redirect_latency();
        int k = 0;
        int n = 0;
        lat = 3; imem_req_ready = 1'b1; if_ready = 1'b1;
        do_reset();
        while (mq.size() != 2 && k < 10) begin
            tick();
            k++;
        end
        checks++;
        if (mq.size() != 2) begin
            errors++;
            $display("FAIL rl_setup: got %0d outstanding after %0d cycles, expected 2", mq.size(), k);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if ({if_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h0000_0100}) begin
            errors++;
            $display("FAIL rl_next: got v=%b req=%b addr=%h, expected 0 1 00000100", if_valid, imem_req_valid, imem_req_addr);
        end
        for (int i = 0; i < 24; i++) begin
            if (if_valid) begin
                checks++;
                if (if_pc !== 32'h0000_0100 + 32'(4 * n)) begin
                    errors++;
                    $display("FAIL rl_seq: got pc=%h, expected %h", if_pc, 32'h0000_0100 + 32'(4 * n));
                end
                n++;
            end
            tick();
            checks++;
            if ({if_valid, if_pc, if_instruction, imem_req_valid} !== {exp_q.size() != 0, exp_pc(), exp_instr(), exp_credit()}) begin
                errors++;
                $display("FAIL rl_model: got v=%b pc=%h ins=%h req=%b, expected v=%b pc=%h ins=%h req=%b",
                         if_valid, if_pc, if_instruction, imem_req_valid, exp_q.size() != 0, exp_pc(), exp_instr(), exp_credit());
            end
        end
        checks++;
        if (n == 0) begin
            errors++;
            $display("FAIL rl_none: got 0 instructions after redirect, expected at least 1");
        end
    endtask

    task automatic test_redirect_collision();
        int n = 0;
        lat = 1; imem_req_ready = 1'b1; if_ready = 1'b1;
        do_reset();
        tick(); tick(); tick(); tick();
        checks++;
        if (!(imem_resp_valid && imem_req_valid)) begin
            errors++;
            $display("FAIL rc_setup: got resp=%b req=%b, expected 1 1", imem_resp_valid, imem_req_valid);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if ({if_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h0000_0200}) begin
            errors++;
            $display("FAIL rc_next: got v=%b req=%b addr=%h, expected 0 1 00000200", if_valid, imem_req_valid, imem_req_addr);
        end
        for (int i = 0; i < 10; i++) begin
            if (if_valid) begin
                checks++;
                if (if_pc !== 32'h0000_0200 + 32'(4 * n) || if_instruction !== if_pc) begin
                    errors++;
                    $display("FAIL rc_seq: got pc=%h ins=%h, expected %h", if_pc, if_instruction, 32'h0000_0200 + 32'(4 * n));
                end
                n++;
            end
            tick();
            checks++;
            if ({if_valid, if_pc, if_instruction, imem_req_valid} !== {exp_q.size() != 0, exp_pc(), exp_instr(), exp_credit()}) begin
                errors++;
                $display("FAIL rc_model: got v=%b pc=%h ins=%h req=%b, expected v=%b pc=%h ins=%h req=%b",
                         if_valid, if_pc, if_instruction, imem_req_valid, exp_q.size() != 0, exp_pc(), exp_instr(), exp_credit());
            end
        end
        checks++;
        if (n == 0) begin
            errors++;
            $display("FAIL rc_none: got 0 instructions after redirect, expected at least 1");
        end
    endtask

    task automatic test_req_stall();
        lat = 1; imem_req_ready = 1'b0; if_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({imem_req_valid, imem_req_addr} !== {1'b1, RST_PC}) begin
                errors++;
                $display("FAIL stall_hold: got req=%b addr=%h, expected 1 %h", imem_req_valid, imem_req_addr, RST_PC);
            end
        end
        imem_req_ready = 1'b1;
        tick();
        checks++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, RST_PC + 32'd4}) begin
            errors++;
            $display("FAIL stall_advance: got req=%b addr=%h, expected 1 %h", imem_req_valid, imem_req_addr, RST_PC + 32'd4);
        end
    endtask

    task automatic test_reset_midstream();
        int k = 0;
        int n = 0;
        lat = 1; imem_req_ready = 1'b1; if_ready = 1'b0;
        do_reset();
        while (exp_q.size() < 2 && k < 10) begin
            tick();
            k++;
        end
        checks++;
        if (if_valid !== 1'b1 || if_pc !== exp_pc() || exp_q.size() < 2) begin
            errors++;
            $display("FAIL rm_setup: got v=%b pc=%h buffered=%0d, expected 1 %h >=2", if_valid, if_pc, exp_q.size(), exp_pc());
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({if_valid, imem_req_valid} !== 2'b00) begin
            errors++;
            $display("FAIL rm_flush: got v=%b req=%b, expected 0 0", if_valid, imem_req_valid);
        end
        rst = 1'b0; if_ready = 1'b1;
        #1;
        checks++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, RST_PC}) begin
            errors++;
            $display("FAIL rm_restart: got req=%b addr=%h, expected 1 %h", imem_req_valid, imem_req_addr, RST_PC);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (if_valid) begin
                checks++;
                if (if_pc !== RST_PC + 32'(4 * n)) begin
                    errors++;
                    $display("FAIL rm_seq: got pc=%h, expected %h", if_pc, RST_PC + 32'(4 * n));
                end
                n++;
            end
        end
        checks++;
        if (n == 0) begin
            errors++;
            $display("FAIL rm_none: got 0 instructions after reset, expected at least 1");
        end
    endtask

    task automatic test_random();
        for (int r = 1; r <= 3; r++) begin
            lat = r; imem_req_ready = 1'b1; if_ready = 1'b1; redirect_valid = 1'b0;
            do_reset();
            for (int i = 0; i < 400; i++) begin
                tick();
                checks++;
                if ({if_valid, if_pc, if_instruction, imem_req_valid} !== {exp_q.size() != 0, exp_pc(), exp_instr(), exp_credit()}) begin
                    errors++;
                    $display("FAIL rand_model lat=%0d i=%0d: got v=%b pc=%h ins=%h req=%b, expected v=%b pc=%h ins=%h req=%b",
                             r, i, if_valid, if_pc, if_instruction, imem_req_valid, exp_q.size() != 0, exp_pc(), exp_instr(), exp_credit());
                end
                if (exp_credit()) begin
                    checks++;
                    if (imem_req_addr !== model_pc) begin
                        errors++;
                        $display("FAIL rand_addr lat=%0d i=%0d: got %h, expected %h", r, i, imem_req_addr, model_pc);
                    end
                end
                imem_req_ready = ($urandom_range(0, 3) != 0);
                if_ready       = ($urandom_range(0, 2) != 0);
                redirect_valid = ($urandom_range(0, 15) == 0);
                redirect_pc    = $urandom;
            end
            redirect_valid = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_latency();
        test_redirect_collision();
        test_req_stall();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
